steer_quad_encoder: RTL and testbench

STEER_QUAD_ENCODER -- requirements
Module: steer_quad_encoder

---
 rtl/sprint4_pkg.sv | 52 +++++
 rtl/steer_rate_gen.sv | 62 ++++++
 rtl/steer_quad_encoder.sv | 131 +++++++++++++
 tb/tb_steer_quad_encoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprint4_pkg.sv
// Shared steering-core definitions: quadrature Gray phases, encoder FSM states,
// decoded steering requests and the helpers that operate on them.
package sprint4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_REPEAT = 2'd2
  } steer_state_e;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2
  } steer_req_e;

  // {A,B} positions in the clockwise (right-turn) order; left walks it backwards.
  localparam logic [1:0] PHASE_0 = 2'b00;
  localparam logic [1:0] PHASE_1 = 2'b01;
  localparam logic [1:0] PHASE_2 = 2'b11;
  localparam logic [1:0] PHASE_3 = 2'b10;

  function automatic logic [1:0] phase_step(input logic [1:0] phase, input logic right);
    logic [1:0] nxt;
    case (phase)
      PHASE_0: nxt = right ? PHASE_1 : PHASE_3;
      PHASE_1: nxt = right ? PHASE_2 : PHASE_0;
      PHASE_2: nxt = right ? PHASE_3 : PHASE_1;
      default: nxt = right ? PHASE_0 : PHASE_2;
    endcase
    return nxt;
  endfunction

  // Invert swaps the joystick meaning; both or neither pressed means no turn.
  function automatic steer_req_e decode_req(input logic left, input logic right,
                                            input logic invert);
    logic eff_left;
    logic eff_right;
    steer_req_e req;
    eff_left  = invert ? right : left;
    eff_right = invert ? left : right;
    if (eff_right && !eff_left) begin
      req = REQ_RIGHT;
    end else if (eff_left && !eff_right) begin
      req = REQ_LEFT;
    end else begin
      req = REQ_NONE;
    end
    return req;
  endfunction

endpackage

// File: rtl/steer_rate_gen.sv
// Accelerating step-rate prescaler: ticks every `period` cycles while running,
// shrinking the period by ACCEL_STEP after each tick down to FAST_DIV.
module steer_rate_gen
  import sprint4_pkg::*;
#(
  parameter int unsigned SLOW_DIV   = 12096,
  parameter int unsigned FAST_DIV   = 3024,
  parameter int unsigned ACCEL_STEP = 756
) (
  input  logic clk_12,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(FAST_DIV - 1);
  localparam logic [31:0] SHRINK_MIN   = 32'(FAST_DIV - 1 + ACCEL_STEP);
  localparam logic [31:0] ACCEL_EXT    = 32'(ACCEL_STEP);

  // The period is stored as period-1 so the SLOW_DIV-1 sized register holds it.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_m1_q, per_m1_d;
  logic [31:0]      per_ext;

  assign tick    = run && (cnt_q == per_m1_q);
  assign per_ext = 32'(per_m1_q);

  always_comb begin
    cnt_d    = cnt_q;
    per_m1_d = per_m1_q;
    if (clear) begin
      cnt_d    = '0;
      per_m1_d = SLOW_M1;
    end else if (run) begin
      if (cnt_q == per_m1_q) begin
        cnt_d = '0;
        // Compare before subtracting so the period can never wrap below FAST_DIV.
        if (per_ext >= SHRINK_MIN) begin
          per_m1_d = CNT_W'(per_ext - ACCEL_EXT);
        end else begin
          per_m1_d = FAST_M1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_12) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      per_m1_q <= SLOW_M1;
    end else begin
      cnt_q    <= cnt_d;
      per_m1_q <= per_m1_d;
    end
  end

endmodule

// File: rtl/steer_quad_encoder.sv
// Turns a digital left/right steering request into an accelerating quadrature
// pulse train, one Gray step at a time, for one player's steering receiver.
module steer_quad_encoder
  import sprint4_pkg::*;
#(
  parameter int unsigned SLOW_DIV   = 12096,
  parameter int unsigned FAST_DIV   = 3024,
  parameter int unsigned ACCEL_STEP = 756
) (
  input  logic         clk_12,
  input  logic         Reset_I,
  input  logic         Left_I,
  input  logic         Right_I,
  input  logic         Invert_I,
  output logic         QuadA_O,
  output logic         QuadB_O,
  output logic         Dir_O,
  output logic         Step_O,
  output steer_state_e dbg_state_o
);

  // Handshake: none. Step_O is a strobe, valid for exactly the cycle in which
  // {QuadA_O,QuadB_O} and Dir_O take their new values; there is no back-pressure.

  logic         left_q, left_d;
  logic         right_q, right_d;
  logic         invert_q, invert_d;
  steer_state_e state_q, state_d;
  logic [1:0]   phase_q, phase_d;
  logic         dir_q, dir_d;
  logic         step_q, step_d;

  steer_req_e   req;
  logic         req_right;
  logic         take_step;
  logic         rate_run;
  logic         rate_clear;
  logic         rate_tick;

  assign req       = decode_req(left_q, right_q, invert_q);
  assign req_right = (req == REQ_RIGHT);

  // The prescaler only advances while repeating in an unchanged direction.
  assign rate_run   = (state_q == ST_REPEAT) && (req != REQ_NONE) && (req_right == dir_q);
  assign rate_clear = !rate_run;

  steer_rate_gen #(
    .SLOW_DIV  (SLOW_DIV),
    .FAST_DIV  (FAST_DIV),
    .ACCEL_STEP(ACCEL_STEP)
  ) u_rate (
    .clk_12(clk_12),
    .rst_n (Reset_I),
    .clear (rate_clear),
    .run   (rate_run),
    .tick  (rate_tick)
  );

  always_comb begin
    left_d    = Left_I;
    right_d   = Right_I;
    invert_d  = Invert_I;
    state_d   = state_q;
    phase_d   = phase_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    take_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != REQ_NONE) begin
          state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (req == REQ_NONE) begin
          state_d = ST_IDLE;
        end else begin
          take_step = 1'b1;
          state_d   = ST_REPEAT;
        end
      end
      ST_REPEAT: begin
        if (req == REQ_NONE) begin
          state_d = ST_IDLE;
        end else if (req_right != dir_q) begin
          // Reversal: restart the turn so the new direction steps at once.
          state_d = ST_FIRST;
        end else if (rate_tick) begin
          take_step = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (take_step) begin
      phase_d = phase_step(phase_q, req_right);
      dir_d   = req_right;
      step_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_12) begin
    if (!Reset_I) begin
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      invert_q <= 1'b0;
      state_q  <= ST_IDLE;
      phase_q  <= PHASE_0;
      dir_q    <= 1'b1;
      step_q   <= 1'b0;
    end else begin
      left_q   <= left_d;
      right_q  <= right_d;
      invert_q <= invert_d;
      state_q  <= state_d;
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
    end
  end

  assign QuadA_O     = phase_q[1];
  assign QuadB_O     = phase_q[0];
  assign Dir_O       = dir_q;
  assign Step_O      = step_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_steer_quad_encoder.sv
// Bench for steer_quad_encoder: directed turn scenarios plus random joystick
// traffic, scored against an edge-scheduled reference model.
module tb_steer_quad_encoder;
  import sprint4_pkg::*;

  localparam int SLOW  = 8;
  localparam int FAST  = 4;
  localparam int ACCEL = 2;
  localparam int EXP_W = 35;  // {edge[31:0], dir, quad[1:0]}

  // ---------------- clock / reset / DUT ----------------
  logic         clk_12   = 1'b0;
  logic         Reset_I  = 1'b0;
  logic         Left_I   = 1'b0;
  logic         Right_I  = 1'b0;
  logic         Invert_I = 1'b0;
  logic         QuadA_O, QuadB_O, Dir_O, Step_O;
  steer_state_e dbg_state;

  steer_quad_encoder #(
    .SLOW_DIV(SLOW), .FAST_DIV(FAST), .ACCEL_STEP(ACCEL)
  ) dut (
    .clk_12     (clk_12),
    .Reset_I    (Reset_I),
    .Left_I     (Left_I),
    .Right_I    (Right_I),
    .Invert_I   (Invert_I),
    .QuadA_O    (QuadA_O),
    .QuadB_O    (QuadB_O),
    .Dir_O      (Dir_O),
    .Step_O     (Step_O),
    .dbg_state_o(dbg_state)
  );

  always #5 clk_12 = ~clk_12;

  int   edge_cnt = 0;
  logic rst_n_at_edge = 1'b0;
  always @(posedge clk_12) begin
    edge_cnt      <= edge_cnt + 1;
    rst_n_at_edge <= Reset_I;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] seen_q[$];

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Turn bookkeeping in absolute edge numbers: a new turn steps one edge after
  // its request is seen, then steps follow at a shrinking gap.
  int m_req;     // request the core sees at the next edge: 0 none, 1 left, 2 right
  int m_mode;    // 0 no turn, 1 first step due next edge, 2 repeating
  int m_next;    // edge of the next repeating step
  int m_gap;
  int m_pos;     // signed step position; phase is derived from it
  bit m_dir;
  logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int eff_req(input bit l, input bit r, input bit inv);
    bit el, er;
    el = inv ? r : l;
    er = inv ? l : r;
    if (er && !el) return 2;
    if (el && !er) return 1;
    return 0;
  endfunction

  task automatic model_emit(input int e, input bit right);
    m_pos = right ? m_pos + 1 : m_pos - 1;
    m_dir = right;
    exp_q.push_back({32'(e), m_dir, gray_tab[m_pos & 3]});
  endtask

  task automatic model_edge(input int e, input bit rst_n, input bit l, input bit r, input bit inv);
    int seen;
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_dir = 1'b1; m_req = 0;
      return;
    end
    seen  = m_req;
    m_req = eff_req(l, r, inv);
    if (seen == 0) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      model_emit(e, seen == 2);
      m_gap  = SLOW;
      m_next = e + SLOW;
      m_mode = 2;
    end else if ((seen == 2) != m_dir) begin
      m_mode = 1;
    end else if (e == m_next) begin
      model_emit(e, seen == 2);
      m_gap  = (m_gap - ACCEL >= FAST) ? m_gap - ACCEL : FAST;
      m_next = e + m_gap;
    end
  endtask

  // ---------------- driver ----------------
  int drv_first;

  task automatic drive(input bit rst_n, input bit l, input bit r, input bit inv, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_12);
      if (i == 0) drv_first = edge_cnt;
      Reset_I = rst_n; Left_I = l; Right_I = r; Invert_I = inv;
      model_edge(edge_cnt, rst_n, l, r, inv);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    @(posedge clk_12);
    #1;
    cmp({name, "_quad"}, {QuadA_O, QuadB_O}, 2'b00);
    cmp({name, "_dir"}, Dir_O, 1'b1);
    cmp({name, "_step"}, Step_O, 1'b0);
    cmp({name, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic check_seen(input string name, input int idx, input int at_edge,
                            input bit dir, input logic [1:0] quad);
    if (idx < 0 || idx >= seen_q.size()) begin
      cmp({name, "_present"}, seen_q.size(), idx + 1);
    end else begin
      cmp(name, seen_q[idx], {32'(at_edge), dir, quad});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       prev_step = 1'b0;
  logic [1:0] prev_quad = 2'b00;

  always @(negedge clk_12) begin
    logic [EXP_W-1:0] got;
    logic [EXP_W-1:0] want;
    if (edge_cnt > 0) begin
      got = {32'(edge_cnt - 1), Dir_O, QuadA_O, QuadB_O};
      if (Step_O === 1'b1) begin
        seen_q.push_back(got);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_step: got edge=%0d dir=%0b quad=%b, required no step",
                   edge_cnt - 1, Dir_O, {QuadA_O, QuadB_O});
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL step: got edge=%0d dir=%0b quad=%b required edge=%0d dir=%0b quad=%b",
                     got[34:3], got[2], got[1:0], want[34:3], want[2], want[1:0]);
          end
        end
        cmp("no_back_to_back_step", prev_step, 1'b0);
      end else if (rst_n_at_edge) begin
        cmp("phase_held_without_step", {QuadA_O, QuadB_O}, prev_quad);
      end
      prev_step = Step_O;
      prev_quad = {QuadA_O, QuadB_O};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0, s1, base, nseen;
    bit rl, rr, ri;
    m_req = 0; m_mode = 0; m_pos = 0; m_dir = 1'b1; m_gap = SLOW; m_next = 0;

    drive(0, 0, 0, 0, 2);
    check_reset_outputs("reset");

    // Steady right turn: accelerating timing and clockwise phases.
    seen_q.delete();
    drive(1, 0, 1, 0, 30); s0 = drv_first;
    drive(1, 0, 0, 0, 3);
    cmp("right_count", seen_q.size(), 6);
    check_seen("right0", 0, s0 + 2,  1, 2'b01);
    check_seen("right1", 1, s0 + 10, 1, 2'b11);
    check_seen("right2", 2, s0 + 16, 1, 2'b10);
    check_seen("right3", 3, s0 + 20, 1, 2'b00);
    check_seen("right4", 4, s0 + 24, 1, 2'b01);
    check_seen("right5", 5, s0 + 28, 1, 2'b11);

    drive(0, 0, 0, 0, 1);
    check_reset_outputs("reset2");

    // Steady left turn.
    seen_q.delete();
    drive(1, 1, 0, 0, 22); s0 = drv_first;
    drive(1, 0, 0, 0, 3);
    check_seen("left0", 0, s0 + 2,  0, 2'b10);
    check_seen("left1", 1, s0 + 10, 0, 2'b11);
    check_seen("left2", 2, s0 + 16, 0, 2'b01);
    check_seen("left3", 3, s0 + 20, 0, 2'b00);

    drive(0, 0, 0, 0, 1);
    check_reset_outputs("reset3");

    // Reversal at the phase-11 point.
    seen_q.delete();
    drive(1, 0, 1, 0, 11); s0 = drv_first;
    drive(1, 1, 0, 0, 12); s1 = drv_first;
    drive(1, 0, 0, 0, 3);
    cmp("reverse_count", seen_q.size(), 4);
    check_seen("reverse_pre0", 0, s0 + 2,  1, 2'b01);
    check_seen("reverse_pre1", 1, s0 + 10, 1, 2'b11);
    check_seen("reverse_step", 2, s1 + 2,  0, 2'b01);
    check_seen("reverse_next", 3, s1 + 10, 0, 2'b00);

    // Both pressed, plain and inverted: no motion.
    seen_q.delete();
    drive(1, 1, 1, 0, 25);
    drive(1, 1, 1, 1, 25);
    drive(1, 0, 0, 0, 2);
    cmp("both_pressed_steps", seen_q.size(), 0);

    // Inverted right behaves as left.
    seen_q.delete();
    drive(1, 0, 1, 1, 22); s0 = drv_first;
    drive(1, 0, 0, 0, 3);
    check_seen("invert0", 0, s0 + 2,  0, 2'b10);
    check_seen("invert1", 1, s0 + 10, 0, 2'b11);
    check_seen("invert3", 3, s0 + 20, 0, 2'b00);

    // Reset mid-turn at phase 11 with right still held.
    drive(0, 0, 0, 0, 1);
    check_reset_outputs("reset4");
    seen_q.delete();
    drive(1, 0, 1, 0, 12);
    drive(0, 0, 1, 0, 1);
    check_reset_outputs("midturn_reset");
    drive(1, 0, 1, 0, 6); base = drv_first;
    drive(1, 0, 0, 0, 3);
    cmp("midturn_count", seen_q.size(), 3);
    check_seen("midturn_pre", 1, base - 3, 1, 2'b11);
    check_seen("after_release", 2, base + 2, 1, 2'b01);

    // One-cycle release restarts the slow period.
    drive(1, 0, 1, 0, 20);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 12); s0 = drv_first;
    drive(1, 0, 0, 0, 3);
    nseen = seen_q.size();
    cmp("repress_first_edge", seen_q[nseen - 2][34:3], s0 + 2);
    cmp("repress_next_edge",  seen_q[nseen - 1][34:3], s0 + 10);

    // Random joystick traffic with occasional one-cycle resets.
    for (int seg = 0; seg < 80; seg++) begin
      if ($urandom_range(0, 14) == 0) drive(0, 0, 0, 0, 1);
      rl = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      ri = 1'($urandom_range(0, 3) == 0);
      drive(1, rl, rr, ri, $urandom_range(1, 40));
    end

    drive(1, 0, 0, 0, 6);
    cmp("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
